// File: rtl/cpu_pkg.sv
// Shared decode/issue definitions: instruction classes, ALU opcodes, special registers.
// Used by decode_stage and reg_scoreboard (the latter only under DECODE_HAZARD_CHECK_EN).
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned REG_AW = 4;

    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_LS  = 2'b01,
        CLS_BR  = 2'b10,
        CLS_UND = 2'b11
    } cls_e;

    localparam logic [3:0] OP_ADD     = 4'b0100;
    localparam logic [3:0] OP_MOV     = 4'b1101;
    localparam logic [3:0] OP_MVN     = 4'b1111;
    localparam logic [1:0] OP_CMP_GRP = 2'b10;

    localparam logic [REG_AW-1:0] REG_PC = 4'd15;
    localparam logic [REG_AW-1:0] REG_LR = 4'd14;

    // One issued instruction as seen by the next stage
    typedef struct packed {
        logic              wr_en;
        logic [REG_AW-1:0] wr_addr;
        logic [REG_AW-1:0] r1_addr;
        logic [REG_AW-1:0] r2_addr;
        logic [XLEN-1:0]   imm;
        logic [3:0]        alu_op;
        cls_e              cls;
        logic [3:0]        cond;
    } dec_t;

    // Data-processing immediate: 8-bit value rotated right by twice the 4-bit rotate field
    function automatic logic [XLEN-1:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [XLEN-1:0] v;
        int unsigned     sh;
        v  = XLEN'(imm8);
        sh = 2 * int'(rot);
        return (v >> sh) | (v << (XLEN - sh));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, r15 never tracked.
// Compiled only when DECODE_HAZARD_CHECK_EN is defined.
`ifdef DECODE_HAZARD_CHECK_EN
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    input  logic              i_sq_en,
    input  logic [REG_AW-1:0] i_sq_addr,
    input  logic [REG_AW-1:0] i_rd_a_addr,
    input  logic [REG_AW-1:0] i_rd_b_addr,
    output logic              o_rd_a_busy_c,
    output logic              o_rd_b_busy_c
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // Clears first so that a same-cycle set on the same bit wins
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_clr_en) w_pend_nxt[i_clr_addr] = 1'b0;
        if (i_sq_en)  w_pend_nxt[i_sq_addr]  = 1'b0;
        if (i_set_en && (i_set_addr != REG_PC)) w_pend_nxt[i_set_addr] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pend <= '0;
        else       r_pend <= w_pend_nxt;
    end

    assign o_rd_a_busy_c = r_pend[i_rd_a_addr];
    assign o_rd_b_busy_c = r_pend[i_rd_b_addr];

endmodule
`endif

// File: rtl/decode_stage.sv
// Decode/issue stage: splits an instruction into register-file addresses and control, registers it.
// RAW hazard stalls against a pending-write scoreboard exist only with DECODE_HAZARD_CHECK_EN.
module decode_stage
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [XLEN-1:0]   instr_i,
    input  logic              instr_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [REG_AW-1:0] r1_addr_o,
    output logic [REG_AW-1:0] r2_addr_o,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] wr_addr_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [3:0]        alu_op_o,
    output logic [1:0]        cls_o,
    output logic [3:0]        cond_o,
    output logic [XLEN-1:0]   pc_o
);

    dec_t            w_dec;
    logic            w_r1_need;
    logic            w_r2_need;
    logic            w_hazard;
    logic            w_accept;
    dec_t            r_dec;
    logic            r_valid;
    logic [XLEN-1:0] r_pc;

    // Per-class field decode; unused read ports are forced to r0
    always_comb begin
        w_dec      = '0;
        w_r1_need  = 1'b0;
        w_r2_need  = 1'b0;
        w_dec.cond = instr_i[31:28];
        w_dec.cls  = cls_e'(instr_i[27:26]);
        case (w_dec.cls)
            CLS_DP: begin
                w_dec.alu_op  = instr_i[24:21];
                w_r1_need     = (instr_i[24:21] != OP_MOV) && (instr_i[24:21] != OP_MVN);
                w_r2_need     = !instr_i[25];
                w_dec.wr_en   = (instr_i[24:23] != OP_CMP_GRP);
                w_dec.wr_addr = instr_i[15:12];
                if (instr_i[25]) w_dec.imm = rot_imm(instr_i[7:0], instr_i[11:8]);
            end
            CLS_LS: begin
                w_dec.alu_op  = OP_ADD;
                w_r1_need     = 1'b1;
                w_r2_need     = !instr_i[20];
                w_dec.wr_en   = instr_i[20];
                w_dec.wr_addr = instr_i[15:12];
                w_dec.imm     = XLEN'(instr_i[11:0]);
            end
            CLS_BR: begin
                w_dec.alu_op  = OP_ADD;
                w_dec.wr_en   = instr_i[24];
                w_dec.wr_addr = REG_LR;
                w_dec.imm     = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
            end
            CLS_UND: ;
        endcase
        w_dec.r1_addr = w_r1_need ? instr_i[19:16] : '0;
        w_dec.r2_addr = !w_r2_need ? '0 :
                        ((w_dec.cls == CLS_LS) ? instr_i[15:12] : instr_i[3:0]);
    end

`ifdef DECODE_HAZARD_CHECK_EN
    logic w_r1_busy;
    logic w_r2_busy;

    reg_scoreboard u_sb (
        .i_clk         (clk_i),
        .i_rst         (reset_i),
        .i_set_en      (w_accept & w_dec.wr_en),
        .i_set_addr    (w_dec.wr_addr),
        .i_clr_en      (wb_en_i),
        .i_clr_addr    (wb_addr_i),
        .i_sq_en       (flush_i & r_valid & r_dec.wr_en),
        .i_sq_addr     (r_dec.wr_addr),
        .i_rd_a_addr   (w_dec.r1_addr),
        .i_rd_b_addr   (w_dec.r2_addr),
        .o_rd_a_busy_c (w_r1_busy),
        .o_rd_b_busy_c (w_r2_busy)
    );

    // Registered scoreboard only: a same-cycle retire of a source still stalls
    assign w_hazard = (w_r1_need & w_r1_busy & (w_dec.r1_addr != REG_PC)) |
                      (w_r2_need & w_r2_busy & (w_dec.r2_addr != REG_PC));
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_en_i, wb_addr_i};
    assign w_hazard    = 1'b0;
`endif

    assign w_accept = instr_valid_i & ~w_hazard & ~stall_i & ~flush_i;
    assign stall_o  = instr_valid_i & ~w_accept;

    // Output register: flush > downstream stall (hold) > issue > bubble
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_pc    <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_dec   <= w_dec;
                r_pc    <= pc_i;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o   = r_valid;
    assign wr_en_o   = r_dec.wr_en;
    assign wr_addr_o = r_dec.wr_addr;
    assign r1_addr_o = r_dec.r1_addr;
    assign r2_addr_o = r_dec.r2_addr;
    assign imm_o     = r_dec.imm;
    assign alu_op_o  = r_dec.alu_op;
    assign cls_o     = r_dec.cls;
    assign cond_o    = r_dec.cond;
    assign pc_o      = r_pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs a behavioural model.
// Model follows DECODE_HAZARD_CHECK_EN the same way the design does.
module tb_decode_stage;

`ifdef DECODE_HAZARD_CHECK_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk_i, reset_i, instr_valid_i, stall_i, flush_i, wb_en_i;
    logic [31:0] instr_i, pc_i;
    logic [3:0]  wb_addr_i;
    logic        stall_o, valid_o, wr_en_o;
    logic [3:0]  r1_addr_o, r2_addr_o, wr_addr_o, alu_op_o, cond_o;
    logic [31:0] imm_o, pc_o;
    logic [1:0]  cls_o;

    int   n_pass, n_total;
    bit   exp_stall;
    logic obs_stall;

    typedef struct {
        bit        wr_en, need1, need2, imm_known, alu_known, wa_known;
        bit [3:0]  wr_addr, r1, r2, alu, cond;
        bit [1:0]  cls;
        bit [31:0] imm;
    } dec_m;

    bit        m_valid;
    dec_m      m_d;
    bit [31:0] m_pc;
    bit        m_sb[16];

    decode_stage dut (
        .clk_i(clk_i), .reset_i(reset_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
        .stall_o(stall_o), .valid_o(valid_o), .r1_addr_o(r1_addr_o), .r2_addr_o(r2_addr_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .imm_o(imm_o), .alu_op_o(alu_op_o),
        .cls_o(cls_o), .cond_o(cond_o), .pc_o(pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference decode straight from the instruction-set rules
    function automatic dec_m model_dec(input logic [31:0] ins);
        dec_m            d;
        bit [3:0]        op;
        longint unsigned imm8;
        int              rot;
        d    = '{default: 0};
        d.cond = ins[31:28];
        d.cls  = ins[27:26];
        op   = ins[24:21];
        case (ins[27:26])
            2'b00: begin
                d.alu = op; d.alu_known = 1;
                d.need1 = !(op == 4'd13 || op == 4'd15);
                d.need2 = !ins[25];
                d.wr_en = !(op >= 4'd8 && op <= 4'd11);
                if (ins[25]) begin
                    imm8 = 64'(ins[7:0]);
                    rot  = 2 * int'(ins[11:8]);
                    d.imm = 32'((imm8 >> rot) | (imm8 << (32 - rot)));
                    d.imm_known = 1;
                end
            end
            2'b01: begin
                d.alu = 4'd4; d.alu_known = 1;
                d.need1 = 1; d.need2 = !ins[20]; d.wr_en = ins[20];
                d.imm = 32'(ins[11:0]); d.imm_known = 1;
            end
            2'b10: begin
                d.alu = 4'd4; d.alu_known = 1;
                d.imm = 32'(int'(signed'(ins[23:0])) * 4); d.imm_known = 1;
                d.wr_en = ins[24];
            end
            default: ;
        endcase
        d.wr_addr  = (ins[27:26] == 2'b10) ? 4'd14 : ins[15:12];
        d.wa_known = d.wr_en;
        d.r1 = d.need1 ? ins[19:16] : 4'd0;
        d.r2 = d.need2 ? ((ins[27:26] == 2'b01) ? ins[15:12] : ins[3:0]) : 4'd0;
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_d = '{default: 0};
        m_d.imm_known = 1; m_d.alu_known = 1; m_d.wa_known = 1;
        m_pc = 0;
        foreach (m_sb[i]) m_sb[i] = 0;
    endtask

    function automatic logic [87:0] exp_vec();
        return {m_valid, m_d.wr_en, (m_d.wa_known ? m_d.wr_addr : 4'd0), m_d.r1, m_d.r2,
                (m_d.imm_known ? m_d.imm : 32'd0), (m_d.alu_known ? m_d.alu : 4'd0),
                m_d.cls, m_d.cond, m_pc};
    endfunction

    function automatic logic [87:0] obs_vec();
        return {valid_o, wr_en_o, (m_d.wa_known ? wr_addr_o : 4'd0), r1_addr_o, r2_addr_o,
                (m_d.imm_known ? imm_o : 32'd0), (m_d.alu_known ? alu_op_o : 4'd0),
                cls_o, cond_o, pc_o};
    endfunction

    // One clock: sample stall at negedge, advance the model at posedge, return at posedge+1
    task automatic tick();
        dec_m d;
        bit   haz, acc;
        @(negedge clk_i);
        d   = model_dec(instr_i);
        haz = HZ && ((d.need1 && m_sb[d.r1] && d.r1 != 4'd15) ||
                     (d.need2 && m_sb[d.r2] && d.r2 != 4'd15));
        acc = instr_valid_i && !haz && !stall_i && !flush_i;
        exp_stall = instr_valid_i && !acc;
        obs_stall = stall_o;
        @(posedge clk_i);
        if (HZ) begin
            if (wb_en_i) m_sb[wb_addr_i] = 0;
            if (flush_i && m_valid && m_d.wr_en) m_sb[m_d.wr_addr] = 0;
            if (acc && d.wr_en && d.wr_addr != 4'd15) m_sb[d.wr_addr] = 1;
        end
        if (flush_i) m_valid = 0;
        else if (!stall_i) begin
            if (acc) begin m_d = d; m_pc = pc_i; m_valid = 1; end
            else m_valid = 0;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit st, input bit fl, input bit wbe, input logic [3:0] wba);
        instr_valid_i = v; instr_i = ins; pc_i = pc;
        stall_i = st; flush_i = fl; wb_en_i = wbe; wb_addr_i = wba;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        drive(1, ins, pc, 0, 0, 0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!exp_stall) break;
        end
        instr_valid_i = 0;
    endtask

    task automatic test_reset();
        drive(1, 32'hE0813002, 32'h44, 1, 0, 0, 4'd0);
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        n_total++;
        if ({valid_o, wr_en_o, wr_addr_o, r1_addr_o, r2_addr_o, imm_o, alu_op_o, cls_o, cond_o, pc_o} !== 88'd0)
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        else n_pass++;
        n_total++;
        if (stall_o !== 1'b1) $display("FAIL reset_stall: got %b want 1", stall_o);
        else n_pass++;
        @(negedge clk_i);
        reset_i = 0;
        drive(0, 0, 0, 0, 0, 0, 4'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_add();
        issue(32'hE0813002, 32'h100);
        n_total++;
        if ({valid_o, r1_addr_o, r2_addr_o, wr_addr_o, wr_en_o, alu_op_o} !== {1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 4'd4})
            $display("FAIL add_fields: got %b %h %h %h %b %h want 1 1 2 3 1 4",
                     valid_o, r1_addr_o, r2_addr_o, wr_addr_o, wr_en_o, alu_op_o);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL add_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_raw();
        bit done = 0;
        drive(1, 32'hE0434005, 32'h104, 0, 0, 0, 4'd0);
        for (int c = 0; c < 6; c++) begin
            wb_en_i = (c == 2); wb_addr_i = 4'd3;
            tick();
            if (!exp_stall) instr_valid_i = 0;
            n_total++;
            if (obs_stall !== exp_stall) $display("FAIL raw_stall c%0d: got %b want %b", c, obs_stall, exp_stall);
            else n_pass++;
            n_total++;
            if (valid_o !== m_valid) $display("FAIL raw_valid c%0d: got %b want %b", c, valid_o, m_valid);
            else n_pass++;
            if (valid_o === 1'b1 && !done) begin
                done = 1;
                n_total++;
                if ({r1_addr_o, r2_addr_o, wr_addr_o} !== 12'h354)
                    $display("FAIL raw_sub_fields: got %h%h%h want 354", r1_addr_o, r2_addr_o, wr_addr_o);
                else n_pass++;
            end
        end
        drive(0, 0, 0, 0, 0, 1, 4'd4);
        tick();
        wb_en_i = 0;
    endtask

    task automatic test_mov_imm();
        issue(32'hE0821003, 32'h200);
        drive(1, 32'hE3A004FF, 32'h204, 0, 0, 0, 4'd0);
        tick();
        instr_valid_i = 0;
        n_total++;
        if (obs_stall !== 1'b0) $display("FAIL mov_nostall: got %b want 0", obs_stall);
        else n_pass++;
        n_total++;
        if ({imm_o, r1_addr_o, r2_addr_o, wr_en_o, wr_addr_o} !== {32'hFF000000, 4'd0, 4'd0, 1'b1, 4'd0})
            $display("FAIL mov_fields: got %h %h %h %b %h want ff000000 0 0 1 0",
                     imm_o, r1_addr_o, r2_addr_o, wr_en_o, wr_addr_o);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL mov_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 4'd1); tick();
        drive(0, 0, 0, 0, 0, 1, 4'd0); tick();
        wb_en_i = 0;
    endtask

    task automatic test_branch_store();
        issue(32'hEBFFFFFE, 32'h300);
        n_total++;
        if ({imm_o, wr_addr_o, wr_en_o, cls_o, r1_addr_o, r2_addr_o} !== {32'hFFFFFFF8, 4'd14, 1'b1, 2'b10, 4'd0, 4'd0})
            $display("FAIL bl_fields: got %h %h %b %b %h %h want fffffff8 e 1 10 0 0",
                     imm_o, wr_addr_o, wr_en_o, cls_o, r1_addr_o, r2_addr_o);
        else n_pass++;
        issue(32'hE5812004, 32'h304);
        n_total++;
        if ({valid_o, r1_addr_o, r2_addr_o, wr_en_o, imm_o, cls_o} !== {1'b1, 4'd1, 4'd2, 1'b0, 32'd4, 2'b01})
            $display("FAIL str_fields: got %b %h %h %b %h %b want 1 1 2 0 4 01",
                     valid_o, r1_addr_o, r2_addr_o, wr_en_o, imm_o, cls_o);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 4'd14); tick();
        wb_en_i = 0;
    endtask

    task automatic test_flush();
        issue(32'hE0816002, 32'h400);
        drive(0, 0, 0, 0, 1, 0, 4'd0);
        tick();
        flush_i = 0;
        n_total++;
        if (valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", valid_o);
        else n_pass++;
        // squashed producer must not block a reader of r6
        drive(1, 32'hE0867000, 32'h404, 0, 0, 0, 4'd0);
        tick();
        instr_valid_i = 0;
        n_total++;
        if (obs_stall !== 1'b0) $display("FAIL flush_squash_stall: got %b want 0", obs_stall);
        else n_pass++;
        issue(32'hE0816002, 32'h408);
        drive(1, 32'hE0816002, 32'h40C, 0, 0, 1, 4'd6);
        tick();
        drive(1, 32'hE0868000, 32'h410, 0, 0, 0, 4'd0);
        tick();
        n_total++;
        if (obs_stall !== exp_stall) $display("FAIL set_wins_stall: got %b want %b", obs_stall, exp_stall);
        else n_pass++;
        for (int k = 0; k < 4 && exp_stall; k++) begin
            wb_en_i = 1; wb_addr_i = 4'd6;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 4'd0);
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL set_wins_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        issue(32'hE0819002, 32'h500);
        drive(1, 32'hE08AA009, 32'h504, 1, 0, 0, 4'd0);
        repeat (2) tick();
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL hold_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        #2 reset_i = 1;
        #1;
        model_reset();
        n_total++;
        if ({valid_o, wr_en_o, wr_addr_o, r1_addr_o, r2_addr_o, imm_o, alu_op_o, cls_o, cond_o, pc_o} !== 88'd0)
            $display("FAIL areset_outputs: got %h want 0", obs_vec());
        else n_pass++;
        n_total++;
        if (stall_o !== 1'b1) $display("FAIL areset_stall_hi: got %b want 1", stall_o);
        else n_pass++;
        stall_i = 0;
        #1;
        n_total++;
        if (stall_o !== 1'b0) $display("FAIL areset_stall_lo: got %b want 0", stall_o);
        else n_pass++;
        @(negedge clk_i);
        reset_i = 0;
        instr_valid_i = 0;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1;
        tick();
        instr_valid_i = 0;
        n_total++;
        if ({obs_stall, valid_o, r1_addr_o, wr_addr_o} !== {1'b0, 1'b1, 4'd10, 4'd10})
            $display("FAIL areset_issue: got %b %b %h %h want 0 1 a a", obs_stall, valid_o, r1_addr_o, wr_addr_o);
        else n_pass++;
    endtask

    task automatic test_random();
        exp_stall = 0;
        for (int c = 0; c < 400; c++) begin
            if (!exp_stall) begin
                instr_valid_i = ($urandom_range(0, 3) != 0);
                instr_i = $urandom();
                pc_i = {$urandom(), 2'b00} >> 2;
            end
            stall_i   = ($urandom_range(0, 4) == 0);
            flush_i   = ($urandom_range(0, 9) == 0);
            wb_en_i   = ($urandom_range(0, 2) == 0);
            wb_addr_i = 4'($urandom_range(0, 15));
            tick();
            n_total++;
            if (obs_stall !== exp_stall) $display("FAIL rnd_stall c%0d: got %b want %b", c, obs_stall, exp_stall);
            else n_pass++;
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL rnd_out c%0d: got %h want %h", c, obs_vec(), exp_vec());
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset_i = 1;
        model_reset();
        test_reset();
        test_add();
        test_raw();
        test_mov_imm();
        test_branch_store();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
